serial_printer: RTL
===================

// Module: serial_printer
// PURPOSE
// Synthesizable printer-side endpoint of the SOC output port (OUTR/FGO).
// Takes characters the CPU writes via OUT and acknowledges them with clear_out.
// Buffers them in a small FIFO and shifts them out as 8N1 UART frames on tx_out.
// Sits beside the SOC in the FPGA top level, in place of the simulation-only printer model.
// PARAMETERS
// CLKS_PER_BIT  16  clock cycles per UART bit; >= 2
// FIFO_DEPTH    4   character buffer entries; power of 2, >= 2
// PORTS
// clock      in   1  system clock; all state updates on posedge
// reset_n    in   1  synchronous, active-low reset
// data_in    in   8  SOC OUTR contents (SOC data_out)
// fgo_in     in   1  SOC FGO; 0 = character pending in OUTR
// clear_out  out  1  one-cycle ack; SOC sets FGO=1 on the next edge
// tx_out     out  1  UART serial line; idle high
// busy_out   out  1  1 while a frame is on the line (START..STOP)
// level_out  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// Reset (reset_n=0 at posedge):
// - outputs: clear_out=0, tx_out=1, busy_out=0, level_out=0.
// - internal: FIFO empty, UART state IDLE, armed=0.
// - Reset mid-frame aborts the frame: tx_out=1 after that edge, buffered chars dropped.
// Capture side:
// - armed<=1 on any edge with fgo_in=1.
// - Capture when armed & !fgo_in & !full at edge N:
//   - push data_in into FIFO; clear_out=1 for cycle N..N+1 only; armed<=0.
// - armed stays 0 until fgo_in seen high again, so no double capture.
// - FIFO full with fgo_in=0: no push, clear_out stays 0, CPU stalls on SKO.
// UART side, state machine IDLE->START->DATA->STOP->IDLE:
// - IDLE, FIFO non-empty: pop, load shift reg, enter START.
//   - tx_out=0 from the edge after the pop.
// - START: one bit period (CLKS_PER_BIT cycles), tx_out=0.
// - DATA: 8 bit periods, LSB first, bit index 0..7.
// - STOP: one bit period, tx_out=1. Then IDLE; pop same edge if non-empty.
// - Back-to-back frames: exactly 10*CLKS_PER_BIT cycles per frame, no idle gap.
// - busy_out=1 in START/DATA/STOP.
// - Bit counter: counts 0..CLKS_PER_BIT-1, wraps, advances on terminal count.
// Latency and FIFO rules:
// - Empty FIFO, UART idle: capture at edge N, pop at N+1, start bit begins at N+2.
// - Simultaneous push and pop: both occur, level_out unchanged.
// - Pop when empty, or push when full: never issued.
// STRUCTURE
// io_pkg holds:
// - uart_state_e {IDLE,START,DATA,STOP}
// - UART_DATA_BITS=8
// - UART_FRAME_BITS=10
// Sub-module sync_fifo #(WIDTH=8, DEPTH):
// - push/pop/full/empty/level; registered read data.
// - Reused later by the keyboard-side receiver.
// serial_printer: capture FSM, UART TX FSM, baud counter, shift reg.
// TESTING
// Reset: hold reset_n=0 3 cycles -> tx_out=1, clear_out=0, busy_out=0, level_out=0.
// Single char: fgo 1->0, data_in=8'h41, CLKS_PER_BIT=4.
//   -> one clear_out pulse.
//   -> tx_out bits 0,1,0,0,0,0,0,1,0,1, each 4 cycles.
// No double ack: fgo_in held 0 for 20 cycles -> exactly one clear_out pulse, level_out peaks at 1.
// Burst: 'H','i','!' written as fast as FGO allows.
//   -> three contiguous frames, 120 cycles total at CLKS_PER_BIT=4.
// Full FIFO, DEPTH=4, CLKS_PER_BIT=16: 6 rapid writes.
//   -> clear_out withheld while level_out=4.
//   -> all 6 chars eventually sent, in order.
// Reset mid-frame: reset_n=0 during bit 3 of 'A'.
//   -> tx_out=1 next edge; level_out=0; no further frame.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the SOC character I/O endpoints.
package io_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/serial_printer_if.sv
// SOC output-port handshake: OUTR contents, FGO flag and the printer's ack.
interface serial_printer_if;
  logic [7:0] data_in;
  logic       fgo_in;
  logic       clear_out;

  modport master (output data_in, output fgo_in, input clear_out);
  modport slave  (input data_in, input fgo_in, output clear_out);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered read data (valid the cycle after pop).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      o_rdata <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop) begin
        o_rdata <= r_mem[r_rp];
        r_rp    <= r_rp + AW'(1);
      end
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
endmodule

// File: rtl/serial_printer.sv
// Printer-side endpoint of the SOC output port: acks OUT writes, buffers them,
// and sends each character as an 8N1 UART frame on tx_out.
module serial_printer
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  serial_printer_if.slave              bus,
  output logic                         tx_out,
  output logic                         busy_out,
  output logic [$clog2(FIFO_DEPTH):0]  level_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic        r_armed, r_clear;
  logic        w_cap, w_pop, w_full, w_empty, w_tc;
  logic [7:0]  w_rdata;
  uart_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx, r_launch;

  // Armed only after FGO has been seen high, so a held-low FGO acks once.
  assign w_cap = r_armed & ~bus.fgo_in & ~w_full;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_clear <= w_cap;
      if (bus.fgo_in)  r_armed <= 1'b1;
      else if (w_cap)  r_armed <= 1'b0;
    end
  end

  assign bus.clear_out = r_clear;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_cap),
    .i_wdata (bus.data_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_out)
  );

  assign w_tc  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  // Read data arrives a cycle after the pop; the shift reg loads at the end of START.
  assign w_pop = ~w_empty & (((r_state == IDLE) & ~r_launch) | ((r_state == STOP) & w_tc));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_launch <= 1'b0;
    end else begin
      r_launch <= 1'b0;
      if (r_state != IDLE) r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        IDLE: begin
          if (r_launch) begin
            r_state <= START;
            r_tx    <= 1'b0;
          end else if (!w_empty) begin
            r_launch <= 1'b1;
          end
        end
        START: if (w_tc) begin
          r_state <= DATA;
          r_shift <= w_rdata;
          r_tx    <= w_rdata[0];
          r_bit   <= '0;
        end
        DATA: if (w_tc) begin
          if (r_bit == 3'(UART_DATA_BITS - 1)) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end else begin
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_bit   <= r_bit + 3'd1;
          end
        end
        STOP: if (w_tc) begin
          if (!w_empty) begin
            r_state <= START;
            r_tx    <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_out   = r_tx;
  assign busy_out = (r_state != IDLE);
endmodule
